// File: rtl/pcmcia_spi_pkg.sv
// Shared definitions for the PCMCIA I/O-space SPI bridge: register offsets,
// STATUS/CTRL bit positions, SPI engine states and the default divider.
package pcmcia_spi_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_INT  = 2;
  localparam int ST_OVR  = 3;

  localparam int CT_SS_EN   = 0;
  localparam int CT_DONE_IE = 1;
  localparam int CT_INT_IE  = 2;

  localparam logic [7:0] DIV_RESET_DEFAULT = 8'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI master byte engine: SCLK half-period of div+1 clocks, MSB first,
// MISO captured on the rising SCLK phase and merged on the following fall.
module spi_shift_engine
  import pcmcia_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic [7:0] div,
  output logic       busy,
  output logic       done_pulse,
  output logic [7:0] rx,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO
);

  spi_state_e r_state;
  spi_state_e w_next;
  logic [7:0] r_cnt;
  logic [7:0] r_div_l;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic [7:0] r_rx;
  logic       r_sample;
  logic       r_sclk;
  logic       w_phase_end;

  assign w_phase_end = (r_cnt == r_div_l);

  always_comb begin
    w_next     = r_state;
    done_pulse = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOW;
      S_LOW:  if (w_phase_end) w_next = S_HIGH;
      S_HIGH: begin
        if (w_phase_end) begin
          if (r_bit == 3'd7) begin
            w_next     = S_IDLE;
            done_pulse = 1'b1;
          end else begin
            w_next = S_LOW;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The sampled MISO bit is held separately so tx bit0 survives until it is shifted out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_div_l  <= 8'd0;
      r_bit    <= 3'd0;
      r_shift  <= 8'd0;
      r_rx     <= 8'd0;
      r_sample <= 1'b0;
      r_sclk   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift <= tx;
            r_div_l <= div;
            r_cnt   <= 8'd0;
            r_bit   <= 3'd0;
          end
        end
        S_LOW: begin
          if (w_phase_end) begin
            r_cnt    <= 8'd0;
            r_sclk   <= 1'b1;
            r_sample <= MISO;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_HIGH: begin
          if (w_phase_end) begin
            r_cnt  <= 8'd0;
            r_sclk <= 1'b0;
            r_bit  <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_rx <= {r_shift[6:0], r_sample};
            else               r_shift <= {r_shift[6:0], r_sample};
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign rx   = r_rx;
  assign SCLK = r_sclk;
  assign MOSI = r_shift[7];

endmodule

// File: rtl/pcmcia_spi_bridge.sv
// PCMCIA I/O-space register block driving an SPI master; host strobes and the
// slave INT pin are synchronised into clk_26 before they touch any state.
module pcmcia_spi_bridge
  import pcmcia_spi_pkg::*;
#(
  parameter logic [11:0] IO_BASE   = 12'h000,
  parameter logic [7:0]  DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic        clk_26,
  input  logic        RESET,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  input  logic        IOWR,
  input  logic        IORD,
  input  logic        CE1,
  output logic [7:0]  D_out,
  output logic        DDIR,
  output logic        SS,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  input  logic        INT,
  output logic        IREQ_N
);

  logic       r_wr_s1, r_wr_s2, r_wr_s3;
  logic       r_rd_s1, r_rd_s2, r_rd_s3;
  logic       r_int_s1, r_int_s2;
  logic       r_rd_data_hit;
  logic       r_done, r_ovr, r_ireq_n;
  logic [2:0] r_ctrl;
  logic [7:0] r_div;

  logic       w_sel, w_in_win, w_wr_fall, w_rd_fall, w_rd_rise, w_wr_hit;
  logic       w_start, w_busy, w_done_pulse, w_done_clr, w_ovr_set, w_ovr_clr;
  logic [7:0] w_rx, w_status, w_rdata;

  assign w_sel    = ~CE1 & (A[15:4] == IO_BASE);
  assign w_in_win = (A[3:2] == 2'b00);
  assign DDIR     = w_sel & ~IORD & w_in_win;
  assign w_status = {4'b0000, r_ovr, r_int_s2, r_done, w_busy};

  always_comb begin
    w_rdata = 8'h00;
    case (A[1:0])
      REG_DATA:   w_rdata = w_rx;
      REG_STATUS: w_rdata = w_status;
      REG_CTRL:   w_rdata = {5'b00000, r_ctrl};
      default:    w_rdata = r_div;
    endcase
  end

  assign D_out = DDIR ? w_rdata : 8'h00;

  // Third flop of each strobe chain only serves edge detection.
  always_ff @(posedge clk_26 or posedge RESET) begin
    if (RESET) begin
      {r_wr_s1, r_wr_s2, r_wr_s3} <= 3'b111;
      {r_rd_s1, r_rd_s2, r_rd_s3} <= 3'b111;
      {r_int_s1, r_int_s2}        <= 2'b00;
    end else begin
      {r_wr_s1, r_wr_s2, r_wr_s3} <= {IOWR, r_wr_s1, r_wr_s2};
      {r_rd_s1, r_rd_s2, r_rd_s3} <= {IORD, r_rd_s1, r_rd_s2};
      {r_int_s1, r_int_s2}        <= {INT, r_int_s1};
    end
  end

  assign w_wr_fall  = r_wr_s3 & ~r_wr_s2;
  assign w_rd_fall  = r_rd_s3 & ~r_rd_s2;
  assign w_rd_rise  = ~r_rd_s3 & r_rd_s2;
  assign w_wr_hit   = w_wr_fall & w_sel & w_in_win;
  assign w_start    = w_wr_hit & (A[1:0] == REG_DATA) & ~w_busy;
  assign w_ovr_set  = w_wr_hit & (A[1:0] == REG_DATA) & w_busy;
  assign w_ovr_clr  = w_wr_hit & (A[1:0] == REG_STATUS) & D_in[ST_OVR];
  assign w_done_clr = w_start | (w_rd_rise & r_rd_data_hit);

  always_ff @(posedge clk_26 or posedge RESET) begin
    if (RESET) begin
      r_ctrl        <= 3'b000;
      r_div         <= DIV_RESET;
      r_rd_data_hit <= 1'b0;
      r_done        <= 1'b0;
      r_ovr         <= 1'b0;
      r_ireq_n      <= 1'b1;
    end else begin
      if (w_wr_hit && A[1:0] == REG_CTRL) r_ctrl <= D_in[2:0];
      if (w_wr_hit && A[1:0] == REG_DIV)  r_div  <= D_in;
      if (w_rd_fall) r_rd_data_hit <= w_sel & (A[3:0] == 4'd0);
      if (w_done_pulse)    r_done <= 1'b1;
      else if (w_done_clr) r_done <= 1'b0;
      if (w_ovr_set)       r_ovr <= 1'b1;
      else if (w_ovr_clr)  r_ovr <= 1'b0;
      r_ireq_n <= ~((r_done & r_ctrl[CT_DONE_IE]) | (r_int_s2 & r_ctrl[CT_INT_IE]));
    end
  end

  assign SS     = ~r_ctrl[CT_SS_EN];
  assign IREQ_N = r_ireq_n;

  spi_shift_engine u_engine (
    .clk        (clk_26),
    .rst        (RESET),
    .start      (w_start),
    .tx         (D_in),
    .div        (r_div),
    .busy       (w_busy),
    .done_pulse (w_done_pulse),
    .rx         (w_rx),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .MISO       (MISO)
  );

endmodule

// File: tb/tb_pcmcia_spi_bridge.sv
// Self-checking bench for pcmcia_spi_bridge: host bus tasks, an SCLK/MOSI
// monitor and a byte-level slave model driving MISO.
module tb_pcmcia_spi_bridge;

  logic        clk_26 = 1'b0;
  logic        RESET;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic        IOWR, IORD, CE1, MISO, INT;
  logic [7:0]  D_out;
  logic        DDIR, SS, SCLK, MOSI, IREQ_N;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       mon_en   = 1'b0;
  logic       loopback = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic       sclk_prev  = 1'b0;
  int         nfall = 0;
  int         rise_q[$];
  int         fall_q[$];
  logic       mosi_q[$];

  pcmcia_spi_bridge dut (
    .clk_26 (clk_26),
    .RESET  (RESET),
    .A      (A),
    .D_in   (D_in),
    .IOWR   (IOWR),
    .IORD   (IORD),
    .CE1    (CE1),
    .D_out  (D_out),
    .DDIR   (DDIR),
    .SS     (SS),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO),
    .INT    (INT),
    .IREQ_N (IREQ_N)
  );

  always #19 clk_26 = ~clk_26;

  always @(posedge clk_26) cyc <= cyc + 1;

  // Slave shifts its byte out MSB first, advancing after every SCLK fall.
  always_comb begin
    MISO = 1'b0;
    if (loopback)       MISO = MOSI;
    else if (nfall < 8) MISO = slave_byte[3'(7 - nfall)];
  end

  always @(negedge clk_26) begin
    if (!mon_en) begin
      rise_q.delete();
      fall_q.delete();
      mosi_q.delete();
      nfall <= 0;
    end else begin
      if (SCLK && !sclk_prev) begin
        rise_q.push_back(cyc);
        mosi_q.push_back(MOSI);
      end
      if (!SCLK && sclk_prev) begin
        fall_q.push_back(cyc);
        nfall <= nfall + 1;
      end
    end
    sclk_prev <= SCLK;
  end

  initial begin
    #(38 * 60000);
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data, output int t0);
    @(negedge clk_26);
    A = addr; D_in = data; CE1 = 1'b0; IOWR = 1'b0; t0 = cyc;
    repeat (4) @(negedge clk_26);
    IOWR = 1'b1;
    repeat (3) @(negedge clk_26);
    CE1 = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic ce, output logic [7:0] data, output logic dd);
    @(negedge clk_26);
    A = addr; CE1 = ce; IORD = 1'b0;
    #1;
    data = D_out; dd = DDIR;
    repeat (4) @(negedge clk_26);
    IORD = 1'b1;
    repeat (3) @(negedge clk_26);
    CE1 = 1'b1;
  endtask

  task automatic wait_done(input int budget, output int td, output bit ok);
    ok = 1'b0; td = 0;
    @(negedge clk_26);
    A = 16'h0001; CE1 = 1'b0; IORD = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_26); #1;
      if (D_out[1] === 1'b1) begin ok = 1'b1; td = cyc; break; end
    end
    IORD = 1'b1;
    repeat (3) @(negedge clk_26);
    CE1 = 1'b1;
  endtask

  task automatic mon_restart(input logic [7:0] sl, input logic loop);
    mon_en = 1'b0;
    repeat (2) @(negedge clk_26);
    slave_byte = sl; loopback = loop; mon_en = 1'b1;
  endtask

  task automatic check_waveform(input logic [7:0] tx, input int d, input string nm);
    logic [7:0] obs;
    int nbad;
    total++;
    if (rise_q.size() !== 8 || fall_q.size() !== 8) begin
      bad++;
      $display("FAIL %s sclk_pulses: rises=%0d falls=%0d required 8", nm, rise_q.size(), fall_q.size());
    end else begin
      obs = 8'h00; nbad = 0;
      for (int i = 0; i < 8; i++) begin
        obs[7-i] = mosi_q[i];
        if (fall_q[i] - rise_q[i] != d + 1) nbad++;
        if (i < 7 && rise_q[i+1] - rise_q[i] != 2 * (d + 1)) nbad++;
      end
      total++;
      if (nbad !== 0) begin
        bad++;
        $display("FAIL %s sclk_timing: %0d bad phases, required half-period %0d", nm, nbad, d + 1);
      end
      total++;
      if (obs !== tx) begin
        bad++;
        $display("FAIL %s mosi_bits: got %02h required %02h", nm, obs, tx);
      end
    end
  endtask

  task automatic run_xfer(input logic [7:0] tx, input int d, input logic [7:0] sl, input logic loop, input string nm);
    logic [7:0] rd, exp_rx;
    logic dd;
    int t0, td, lat;
    bit ok;
    exp_rx = loop ? tx : sl;
    mon_restart(sl, loop);
    bus_write(16'h0000, tx, t0);
    wait_done(16 * (d + 1) + 40, td, ok);
    lat = td - t0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s done_timeout: DONE not seen, required within %0d cycles", nm, 16 * (d + 1) + 3);
    end else if (lat < 16 * (d + 1) + 2 || lat > 16 * (d + 1) + 3) begin
      bad++;
      $display("FAIL %s done_latency: got %0d required %0d..%0d", nm, lat, 16 * (d + 1) + 2, 16 * (d + 1) + 3);
    end
    check_waveform(tx, d, nm);
    bus_read(16'h0001, 1'b0, rd, dd);
    total++;
    if (rd !== 8'h02) begin bad++; $display("FAIL %s status_done: got %02h required 02", nm, rd); end
    bus_read(16'h0000, 1'b0, rd, dd);
    total++;
    if (rd !== exp_rx) begin bad++; $display("FAIL %s rx_data: got %02h required %02h", nm, rd, exp_rx); end
    bus_read(16'h0001, 1'b0, rd, dd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL %s status_after_read: got %02h required 00", nm, rd); end
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    logic dd;
    int t0;
    RESET = 1'b1;
    repeat (3) @(negedge clk_26);
    #1;
    total++;
    if ({SS, SCLK, MOSI, IREQ_N} !== 4'b1001) begin
      bad++; $display("FAIL reset_pins: SS/SCLK/MOSI/IREQ_N=%b required 1001", {SS, SCLK, MOSI, IREQ_N});
    end
    RESET = 1'b0;
    bus_read(16'h0003, 1'b0, rd, dd);
    total++;
    if (rd !== 8'h0C || dd !== 1'b1) begin bad++; $display("FAIL reset_div: got %02h ddir=%b required 0C ddir=1", rd, dd); end
    bus_write(16'h0002, 8'h01, t0);
    bus_write(16'h0000, 8'hFF, t0);
    repeat (40) @(negedge clk_26);
    #1;
    total++;
    if (SS !== 1'b0 || MOSI !== 1'b1) begin bad++; $display("FAIL reset_pre: SS=%b MOSI=%b required SS=0 MOSI=1", SS, MOSI); end
    RESET = 1'b1;
    #1;
    total++;
    if ({SS, SCLK, MOSI, IREQ_N} !== 4'b1001) begin
      bad++; $display("FAIL reset_mid_pins: SS/SCLK/MOSI/IREQ_N=%b required 1001", {SS, SCLK, MOSI, IREQ_N});
    end
    repeat (2) @(negedge clk_26);
    RESET = 1'b0;
    repeat (20) @(negedge clk_26);
    bus_read(16'h0001, 1'b0, rd, dd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL reset_status: got %02h required 00", rd); end
    bus_read(16'h0003, 1'b0, rd, dd);
    total++;
    if (rd !== 8'h0C) begin bad++; $display("FAIL reset_div_mid: got %02h required 0C", rd); end
    bus_read(16'h0002, 1'b0, rd, dd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL reset_ctrl: got %02h required 00", rd); end
    bus_read(16'h0000, 1'b0, rd, dd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h required 00", rd); end
  endtask

  task automatic test_loopback();
    int t0;
    bus_write(16'h0003, 8'h00, t0);
    bus_write(16'h0002, 8'h01, t0);
    #1;
    total++;
    if (SS !== 1'b0) begin bad++; $display("FAIL loop_ss: got %b required 0", SS); end
    run_xfer(8'hA5, 0, 8'h00, 1'b1, "loopback");
  endtask

  task automatic test_slave();
    int t0;
    bus_write(16'h0003, 8'h02, t0);
    run_xfer(8'hFF, 2, 8'h3C, 1'b0, "slave3C");
  endtask

  task automatic test_overrun();
    logic [7:0] rd;
    logic dd;
    int t0, td;
    bit ok;
    bus_write(16'h0003, 8'h05, t0);
    mon_restart(8'h00, 1'b1);
    bus_write(16'h0000, 8'h11, t0);
    bus_write(16'h0000, 8'h22, td);
    bus_read(16'h0001, 1'b0, rd, dd);
    total++;
    if (rd !== 8'h09) begin bad++; $display("FAIL ovr_busy_status: got %02h required 09", rd); end
    wait_done(200, td, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ovr_done_timeout: DONE not seen, required within 96 cycles"); end
    bus_read(16'h0001, 1'b0, rd, dd);
    total++;
    if (rd !== 8'h0A) begin bad++; $display("FAIL ovr_done_status: got %02h required 0A", rd); end
    check_waveform(8'h11, 5, "overrun");
    bus_write(16'h0001, 8'h08, t0);
    bus_read(16'h0001, 1'b0, rd, dd);
    total++;
    if (rd !== 8'h02) begin bad++; $display("FAIL ovr_clear: got %02h required 02", rd); end
    bus_read(16'h0000, 1'b0, rd, dd);
    total++;
    if (rd !== 8'h11) begin bad++; $display("FAIL ovr_rx: got %02h required 11", rd); end
    mon_en = 1'b0;
  endtask

  task automatic test_interrupts();
    logic [7:0] rd;
    logic dd;
    int t0, td;
    bit ok, seen;
    bus_write(16'h0003, 8'h01, t0);
    bus_write(16'h0002, 8'h06, t0);
    @(negedge clk_26);
    INT = 1'b1; seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_26); #1;
      if (IREQ_N === 1'b0) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL int_ireq_assert: IREQ_N=%b required 0 within 3 cycles", IREQ_N); end
    bus_read(16'h0001, 1'b0, rd, dd);
    total++;
    if (rd !== 8'h04) begin bad++; $display("FAIL int_status: got %02h required 04", rd); end
    INT = 1'b0;
    repeat (4) @(negedge clk_26);
    #1;
    total++;
    if (IREQ_N !== 1'b1) begin bad++; $display("FAIL int_ireq_release: got %b required 1", IREQ_N); end
    loopback = 1'b1;
    bus_write(16'h0000, 8'h5A, t0);
    wait_done(100, td, ok);
    @(negedge clk_26); #1;
    total++;
    if (!ok || IREQ_N !== 1'b0) begin bad++; $display("FAIL int_done_ireq: done=%b IREQ_N=%b required done=1 IREQ_N=0", ok, IREQ_N); end
    bus_read(16'h0000, 1'b0, rd, dd);
    @(negedge clk_26); #1;
    total++;
    if (IREQ_N !== 1'b1 || rd !== 8'h5A) begin
      bad++; $display("FAIL int_data_read: IREQ_N=%b rx=%02h required IREQ_N=1 rx=5A", IREQ_N, rd);
    end
    bus_write(16'h0002, 8'h01, t0);
  endtask

  task automatic test_decode();
    logic [7:0] rd;
    logic dd;
    int t0;
    bus_read(16'h0005, 1'b0, rd, dd);
    total++;
    if (dd !== 1'b0 || rd !== 8'h00) begin bad++; $display("FAIL dec_offset5: ddir=%b dout=%02h required 0/00", dd, rd); end
    bus_read(16'h0001, 1'b1, rd, dd);
    total++;
    if (dd !== 1'b0 || rd !== 8'h00) begin bad++; $display("FAIL dec_ce1: ddir=%b dout=%02h required 0/00", dd, rd); end
    bus_read(16'h0013, 1'b0, rd, dd);
    total++;
    if (dd !== 1'b0 || rd !== 8'h00) begin bad++; $display("FAIL dec_window: ddir=%b dout=%02h required 0/00", dd, rd); end
    bus_write(16'h0013, 8'h55, t0);
    bus_write(16'h0007, 8'h77, t0);
    bus_write(16'h0006, 8'h07, t0);
    bus_read(16'h0003, 1'b0, rd, dd);
    total++;
    if (dd !== 1'b1 || rd !== 8'h01) begin bad++; $display("FAIL dec_div_kept: ddir=%b div=%02h required 1/01", dd, rd); end
    bus_read(16'h0002, 1'b0, rd, dd);
    total++;
    if (rd !== 8'h01) begin bad++; $display("FAIL dec_ctrl_kept: got %02h required 01", rd); end
  endtask

  task automatic test_random();
    int t0, d;
    logic [7:0] tx, sl;
    for (int n = 0; n < 4; n++) begin
      d  = int'($urandom_range(0, 3));
      tx = 8'($urandom);
      sl = 8'($urandom);
      bus_write(16'h0003, 8'(d), t0);
      run_xfer(tx, d, sl, 1'b0, "random");
    end
  endtask

  initial begin
    A = 16'h0000; D_in = 8'h00; IOWR = 1'b1; IORD = 1'b1; CE1 = 1'b1; INT = 1'b0; RESET = 1'b0;
    test_reset();
    test_loopback();
    test_slave();
    test_overrun();
    test_interrupts();
    test_decode();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcmcia_spi_bridge.md
Name: pcmcia_spi_bridge

Overview:
- Card I/O-space register block that turns host IORD/IOWR cycles into SPI master transfers on SS/SCLK/MOSI/MISO.
- Sits beside the attribute-memory CIS ROM on the card bus. Its D_out/DDIR are ORed/muxed with the ROM's at top level.
- Also exposes the slave INT pin as status and as an optional host interrupt request.

Parameters:
- IO_BASE, 12'h000, match value for A[15:4]; the block decodes A[3:0] inside this 16-byte window.
- DIV_RESET, 8'd12, reset value of DIV register; SCLK half-period = DIV+1 clk_26 cycles.

Ports:
- clk_26  in  1  system clock, 26 MHz
- RESET  in  1  asynchronous, active-high reset
- A  in  16  card address bus
- D_in  in  8  card write data
- IOWR  in  1  I/O write strobe, active low, asynchronous to clk_26
- IORD  in  1  I/O read strobe, active low, asynchronous to clk_26
- CE1  in  1  card enable, active low
- D_out  out  8  read data
- DDIR  out  1  1 = block drives data bus
- SS  out  1  SPI slave select, active low
- SCLK  out  1  SPI clock, mode 0, idles low
- MOSI  out  1  SPI data out, MSB first
- MISO  in  1  SPI data in
- INT  in  1  slave interrupt, active high, asynchronous
- IREQ_N  out  1  host interrupt request, active low

Behaviour:
- Decode: sel = ~CE1 & (A[15:4]==IO_BASE).
- Read path (combinational from raw pins):
  - DDIR = sel & ~IORD & A[3:0]<4.
  - D_out = register at A[1:0] when DDIR, else 8'h00.
- Register map:
  - 0 DATA: write starts a transfer; read returns the last RX byte.
  - 1 STATUS: bit0 BUSY, bit1 DONE, bit2 INT_SYNC, bit3 OVR, bits[7:4] 0. Writing 1 to bit3 clears OVR.
  - 2 CTRL: bit0 SS_EN (SS = ~SS_EN), bit1 DONE_IE, bit2 INT_IE, bits[7:3] read 0.
  - 3 DIV: 8-bit divider.
- Strobe synchronisation:
  - IOWR, IORD and INT each pass through 2-flop synchronisers.
  - Write commits on the synced IOWR falling edge, 2-3 cycles after the pin falls; A and D_in are sampled directly that cycle.
  - Read side effects occur on the synced IORD rising edge, using the A captured at the synced falling edge.
- DATA write while idle:
  - Load TX into shift register; MOSI = bit7; latch DIV into the engine; BUSY=1, DONE=0.
- DATA write while BUSY: ignored; OVR=1.
- DATA read: clears DONE at the end of the read strobe.
- SPI engine FSM:
  - IDLE -> LOW: on start.
  - LOW -> HIGH: after DIV+1 cycles; SCLK=1; MISO sampled into shift lsb on this cycle.
  - HIGH -> LOW: after DIV+1 cycles; SCLK=0; shift left; next bit on MOSI.
  - HIGH -> IDLE: after the 8th high phase ends; SCLK=0, RX=shift, BUSY=0, DONE=1.
  - Total transfer = 16*(DIV+1) cycles from start to DONE.
  - DIV writes during BUSY take effect on the next transfer.
  - SS is purely software (CTRL.SS_EN); the engine never touches SS.
- Simultaneous events:
  - DONE set and DONE clear in the same cycle: set wins.
  - OVR set and OVR clear in the same cycle: set wins.
- IREQ_N = ~((DONE & DONE_IE) | (INT_SYNC & INT_IE)), registered, 1 cycle latency.
- Reset values: SS=1, SCLK=0, MOSI=0, IREQ_N=1, DATA/RX=00, CTRL=00, DIV=DIV_RESET, STATUS=00, FSM=IDLE.
- Reset mid-transfer aborts immediately to the reset values; no DONE is set.
- Writes to offsets 4-15 are ignored and reads of them leave DDIR=0.

Decomposition:
- Shared package pcmcia_spi_pkg: register offsets, STATUS/CTRL bit indices, FSM state encoding, DIV_RESET default.
- One sub-module, spi_shift_engine: FSM, divider counter, bit counter, shift register. Ports: start, tx, div, busy, done_pulse, rx, SCLK, MOSI, MISO.
- Synchronisers are inline 2-flop registers.

Test Plan:
- Reset: RESET pulse mid-transfer -> SS=1, SCLK=0, MOSI=0, IREQ_N=1; STATUS reads 00; DIV reads 0C.
- Loopback: MISO tied to MOSI, DIV=0, write CTRL=01 then DATA=A5 -> SS=0; 8 SCLK pulses, each 1 cycle high/1 low; DONE after 16 cycles; DATA reads A5; STATUS reads 02 then 00 after the DATA read.
- Slave drives 3C, DIV=2, write DATA=FF -> MOSI holds 1 for all bits; SCLK half-period 3 cycles; total 48 cycles to DONE; RX=3C.
- Overrun: write DATA=11 then DATA=22 while BUSY -> only 11 shifted; STATUS=09 while busy, 0A after DONE; write STATUS=08 -> OVR cleared.
- Interrupts: CTRL=06, raise INT -> STATUS bit2=1 and IREQ_N=0 within 3 cycles; drop INT -> IREQ_N=1; after a transfer with DONE_IE -> IREQ_N=0 until DATA read.
- Decode: IORD with A=0x0005 or CE1=1 -> DDIR=0, D_out=00; IOWR with A=0x0013 (IO_BASE=0) -> no register changes.
